// File: rtl/vec_reg_file_if.sv
// ---------------------------------------------------------------------------
// vec_reg_file_if
// Bundles the decode-side and ALU-side signals of the vector register file
// into one interface.
//   master : the decode stage / vector ALU driving requests and reading data
//   slave  : the register file itself
// Signals:
//   we, wa, wmask, wd   write port (per-lane mask)
//   ra1, ra2, rd1, rd2  two asynchronous read ports
//   color_we, color     packed colour-load request
//   busy                clear engine active
//   wr_drop             one-cycle pulse for a discarded request
// ---------------------------------------------------------------------------
interface vec_reg_file_if #(
  parameter int LANES  = 6,
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 16
);
  localparam int VW = LANES * ELEM_W;
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    wa;
  logic [LANES-1:0] wmask;
  logic [VW-1:0]    wd;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [VW-1:0]    rd1;
  logic [VW-1:0]    rd2;
  logic             color_we;
  logic [7:0]       color;
  logic             busy;
  logic             wr_drop;

  modport master (
    output we, wa, wmask, wd, ra1, ra2, color_we, color,
    input  rd1, rd2, busy, wr_drop
  );

  modport slave (
    input  we, wa, wmask, wd, ra1, ra2, color_we, color,
    output rd1, rd2, busy, wr_drop
  );
endinterface

// File: rtl/vec_reg_file.sv
// ---------------------------------------------------------------------------
// vec_reg_file
// Vector register file: DEPTH registers of LANES x ELEM_W bits, two
// combinational read ports, one lane-masked write port and a colour-load
// port that decodes an 8-bit packed colour into a pixel register and an
// alpha register. After reset a clear engine zeroes one register per cycle;
// while it runs reads return zero and any request is dropped (wr_drop).
// Ports:
//   clk  clock
//   rst  synchronous reset, active high
//   bus  vec_reg_file_if.slave (write, read, colour, busy, wr_drop)
// Optional feature:
//   VRF_BYPASS_EN  when defined, a read of the register being written in
//                  the same cycle returns the merged post-write value.
// ---------------------------------------------------------------------------
module vec_reg_file #(
  parameter int LANES     = 6,
  parameter int ELEM_W    = 8,
  parameter int DEPTH     = 16,
  parameter int PIX_REG   = 4,
  parameter int ALPHA_REG = 3,
  parameter int ZERO_R0   = 1
) (
  input logic           clk,
  input logic           rst,
  vec_reg_file_if.slave bus
);

  localparam int VW = LANES * ELEM_W;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic                     wr_drop_q, wr_drop_d;
  logic [DEPTH-1:0][VW-1:0] mem_q, mem_d;
  logic [DEPTH-1:0][VW-1:0] next_all;
  logic [VW-1:0]            pix_val, alpha_val;
  logic [VW-1:0]            src1, src2;
  logic                     busy;

  // 2-bit colour code to element level: 0, quarter-1, three-quarter-1, max.
  function automatic logic [ELEM_W-1:0] level(input logic [1:0] c);
    case (c)
      2'd0:    level = '0;
      2'd1:    level = {2'b00, {(ELEM_W-2){1'b1}}};
      2'd2:    level = {2'b10, {(ELEM_W-2){1'b1}}};
      default: level = '1;
    endcase
  endfunction

  // rst is folded in so busy is high for the whole time reset is held,
  // not just from the first reset edge onwards.
  assign busy = rst | (state_q == CLEAR);

  // Clear engine: walk the index through every register once, then READY.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_drop_d = busy & (bus.we | bus.color_we);
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  // Decoded colour values; lanes cycle b, g, r starting at lane 0.
  always_comb begin
    pix_val   = '0;
    alpha_val = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l % 3 == 0)      pix_val[l*ELEM_W +: ELEM_W] = level(bus.color[7:6]);
      else if (l % 3 == 1) pix_val[l*ELEM_W +: ELEM_W] = level(bus.color[5:4]);
      else                 pix_val[l*ELEM_W +: ELEM_W] = level(bus.color[3:2]);
    end
    case (bus.color[1:0])
      2'd0:    alpha_val[ELEM_W-1:0] = '0;
      2'd1:    alpha_val[ELEM_W-1:0] = ELEM_W'(25);
      2'd2:    alpha_val[ELEM_W-1:0] = ELEM_W'(50);
      default: alpha_val[ELEM_W-1:0] = ELEM_W'(75);
    endcase
  end

  // Post-write value of every register. The colour load is applied first
  // so that the masked lanes of a same-target we write override it.
  always_comb begin
    next_all = mem_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.color_we && r == PIX_REG)   next_all[r] = pix_val;
      if (bus.color_we && r == ALPHA_REG) next_all[r] = alpha_val;
      if (bus.we && bus.wa == AW'(r)) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.wmask[l]) next_all[r][l*ELEM_W +: ELEM_W] = bus.wd[l*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Array update: clear one register per cycle in CLEAR, else commit writes.
  always_comb begin
    mem_d = mem_q;
    if (state_q == READY) begin
      mem_d = next_all;
      if (ZERO_R0 != 0) mem_d[0] = mem_q[0];
    end else begin
      mem_d[idx_q] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
    end
  end

  // next_all equals mem_q when nothing targets the address, so it doubles
  // as the bypass source; busy masking below covers the clear phase.
`ifdef VRF_BYPASS_EN
  assign src1 = next_all[bus.ra1];
  assign src2 = next_all[bus.ra2];
`else
  assign src1 = mem_q[bus.ra1];
  assign src2 = mem_q[bus.ra2];
`endif

  assign bus.rd1     = (busy || (ZERO_R0 != 0 && bus.ra1 == '0)) ? '0 : src1;
  assign bus.rd2     = (busy || (ZERO_R0 != 0 && bus.ra2 == '0)) ? '0 : src2;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q & ~rst;

endmodule
